serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor: a single full-subtractor cell plus a registered borrow, stepped over the operand bits LSB first. It sits directly around the team's full-subtractor cell as its sequencing stage. It accepts two unsigned operands and a borrow-in on a start strobe, and produces one difference bit per clock. It then presents the full parallel difference and final borrow-out with a one-cycle done pulse.

---
 rtl/serial_subtractor.sv | 120 ++++++++++++
 tb/tb_serial_subtractor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell and a registered borrow,
// stepped LSB first over WIDTH bits, then a parallel result with a done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             d_bit,
    output logic             d_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             busy_q, busy_d, d_bit_q, d_bit_d, d_valid_q, d_valid_d;
    logic             bout_q, bout_d, done_q, done_d;
    logic             ai, bi, d_cell, b_cell, last;

    always_comb begin
        ai     = a_q[0];
        bi     = b_q[0];
        d_cell = ai ^ bi ^ br_q;
        b_cell = (~ai & bi) | (~(ai ^ bi) & br_q);
        last   = (cnt_q == CW'(WIDTH - 1));

        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        diff_d    = diff_q;
        cnt_d     = cnt_q;
        br_d      = br_q;
        bout_d    = bout_q;
        busy_d    = 1'b0;
        d_bit_d   = 1'b0;
        d_valid_d = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // busy stays high through the done cycle so chained ops show no gap
                busy_d    = 1'b1;
                d_bit_d   = d_cell;
                d_valid_d = 1'b1;
                res_d     = {d_cell, res_q[WIDTH-1:1]};
                a_d       = a_q >> 1;
                b_d       = b_q >> 1;
                br_d      = b_cell;
                cnt_d     = cnt_q + 1'b1;
                if (last) begin
                    diff_d  = res_d;
                    bout_d  = b_cell;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
            br_q      <= 1'b0;
            bout_q    <= 1'b0;
            busy_q    <= 1'b0;
            d_bit_q   <= 1'b0;
            d_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            diff_q    <= diff_d;
            cnt_q     <= cnt_d;
            br_q      <= br_d;
            bout_q    <= bout_d;
            busy_q    <= busy_d;
            d_bit_q   <= d_bit_d;
            d_valid_q <= d_valid_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign d_bit   = d_bit_q;
    assign d_valid = d_valid_q;
    assign diff    = diff_q;
    assign bout    = bout_q;
    assign done    = done_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH=8 and WIDTH=4.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, bin8 = 1'b0, start4 = 1'b0, bin4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic [3:0] a4 = '0, b4 = '0, diff4;
    logic       busy8, d_bit8, d_valid8, bout8, done8;
    logic       busy4, d_bit4, d_valid4, bout4, done4;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .d_bit(d_bit8), .d_valid(d_valid8), .diff(diff8),
        .bout(bout8), .done(done8));

    serial_subtractor #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .d_bit(d_bit4), .d_valid(d_valid4), .diff(diff4),
        .bout(bout4), .done(done4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and let the capture edge E0 happen.
    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        tick();
        start8 = 1'b0;
    endtask

    // Step through edges E0+1..E0+8 recording the serial stream.
    task automatic collect8(output logic [7:0] stream, output int vcnt,
                            output int done_at, output logic busy_gap);
        stream = '0; vcnt = 0; done_at = 0; busy_gap = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (d_valid8) begin
                stream[i] = d_bit8;
                vcnt++;
            end
            if (done8) done_at = i + 1;
            if (!busy8) busy_gap = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({busy8, d_bit8, d_valid8, diff8, bout8, done8} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {busy8, d_bit8, d_valid8, diff8, bout8, done8});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] s; int v, d; logic g;
        drive8(8'h05, 8'h03, 1'b0);
        checks++;
        if (busy8 !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy8); end
        collect8(s, v, d, g);
        checks++;
        if (s !== 8'h02 || v != 8) begin
            errors++; $display("FAIL basic_stream got %h/%0d want 02/8", s, v);
        end
        checks++;
        if (diff8 !== 8'h02 || bout8 !== 1'b0 || d != 8) begin
            errors++; $display("FAIL basic_result got %h %b done@%0d want 02 0 done@8", diff8, bout8, d);
        end
        tick();
        checks++;
        if (done8 !== 1'b0 || d_valid8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++; $display("FAIL basic_after got done=%b dv=%b busy=%b want 0 0 0", done8, d_valid8, busy8);
        end
        checks++;
        if (diff8 !== 8'h02) begin errors++; $display("FAIL basic_hold got %h want 02", diff8); end
    endtask

    task automatic test_borrow();
        logic [7:0] s; int v, d; logic g;
        drive8(8'h03, 8'h05, 1'b0);
        collect8(s, v, d, g);
        checks++;
        if (diff8 !== 8'hFE || bout8 !== 1'b1 || s !== 8'hFE) begin
            errors++; $display("FAIL borrow_neg got %h %b s=%h want FE 1 s=FE", diff8, bout8, s);
        end
        tick();
        drive8(8'h00, 8'h00, 1'b1);
        collect8(s, v, d, g);
        checks++;
        if (diff8 !== 8'hFF || bout8 !== 1'b1 || s !== 8'hFF) begin
            errors++; $display("FAIL borrow_ripple got %h %b s=%h want FF 1 s=FF", diff8, bout8, s);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] s; int v, d; logic g;
        drive8(8'h80, 8'h80, 1'b0);
        collect8(s, v, d, g);
        checks++;
        if (diff8 !== 8'h00 || bout8 !== 1'b0 || done8 !== 1'b1 || busy8 !== 1'b1) begin
            errors++; $display("FAIL b2b_first got %h %b done=%b busy=%b want 00 0 1 1", diff8, bout8, done8, busy8);
        end
        drive8(8'hFF, 8'h01, 1'b1);
        checks++;
        if (busy8 !== 1'b1 || diff8 !== 8'h00) begin
            errors++; $display("FAIL b2b_start got busy=%b diff=%h want 1 00", busy8, diff8);
        end
        collect8(s, v, d, g);
        checks++;
        if (diff8 !== 8'hFD || bout8 !== 1'b0 || d != 8 || g !== 1'b0) begin
            errors++; $display("FAIL b2b_second got %h %b done@%0d gap=%b want FD 0 8 0", diff8, bout8, d, g);
        end
        tick();
    endtask

    task automatic test_ignore_busy();
        int ndone = 0;
        drive8(8'h05, 8'h03, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            if (i == 3) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; end
            tick();
            start8 = 1'b0;
            if (done8) ndone++;
        end
        checks++;
        if (ndone != 1 || diff8 !== 8'h02 || bout8 !== 1'b0) begin
            errors++; $display("FAIL ignore got dones=%0d %h %b want 1 02 0", ndone, diff8, bout8);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s; int v, d; logic g;
        int ndone = 0;
        drive8(8'h05, 8'h03, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, d_bit8, d_valid8, diff8, bout8, done8} !== 13'h0) begin
            errors++; $display("FAIL midreset_async got %h want 0",
                               {busy8, d_bit8, d_valid8, diff8, bout8, done8});
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done8 || busy8) ndone++;
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL midreset_nodone got %0d want 0", ndone); end
        drive8(8'h10, 8'h20, 1'b0);
        collect8(s, v, d, g);
        checks++;
        if (diff8 !== 8'hF0 || bout8 !== 1'b1 || d != 8) begin
            errors++; $display("FAIL midreset_after got %h %b done@%0d want F0 1 8", diff8, bout8, d);
        end
        tick();
    endtask

    task automatic test_random8();
        logic [7:0] s, ra, rb; logic rc; int v, d; logic g;
        logic [8:0] e;
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            e = {1'b0, ra} - {1'b0, rb} - {8'h00, rc};
            drive8(ra, rb, rc);
            collect8(s, v, d, g);
            checks++;
            if ({bout8, diff8, s} !== {e[8], e[7:0], e[7:0]} || d != 8 || v != 8) begin
                errors++;
                $display("FAIL rand8 %h-%h-%b got %b %h s=%h done@%0d want %b %h", ra, rb, rc,
                         bout8, diff8, s, d, e[8], e[7:0]);
            end
        end
        tick();
    endtask

    task automatic test_random4();
        logic [3:0] s, ra, rb; logic rc; int d;
        logic [4:0] e;
        for (int n = 0; n < 1000; n++) begin
            ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
            e = {1'b0, ra} - {1'b0, rb} - {4'h0, rc};
            start4 = 1'b1; a4 = ra; b4 = rb; bin4 = rc;
            tick();
            start4 = 1'b0; s = '0; d = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (d_valid4) s[i] = d_bit4;
                if (done4) d = i + 1;
            end
            checks++;
            if ({bout4, diff4, s} !== {e[4], e[3:0], e[3:0]} || d != 4) begin
                errors++;
                $display("FAIL rand4 %h-%h-%b got %b %h s=%h done@%0d want %b %h", ra, rb, rc,
                         bout4, diff4, s, d, e[4], e[3:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_random8();
        test_random4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
